// File: rtl/usb_line_rx_pkg.sv
// Shared constants, state type and byte-class helpers for the USB line receiver.
package usb_line_rx_pkg;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_BS  = 8'h08;
   localparam logic [7:0] ASCII_DEL = 8'h7F;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_DRAIN   = 1'b1
   } state_e;

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

   function automatic logic is_erase(input logic [7:0] b);
      return (b == ASCII_BS) || (b == ASCII_DEL);
   endfunction

endpackage

// File: rtl/usb_line_rx_echo_buf.sv
// Single-entry valid/ready holding register for echoed bytes; accepts a new byte
// whenever it is empty or its current byte is leaving in the same cycle.
module usb_line_rx_echo_buf (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready
);

   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/usb_line_rx.sv
// Line receiver: collects UART bytes into a line buffer, then replays the line.
// Optional echo path enabled by defining USB_LINE_RX_ECHO_EN.
module usb_line_rx
   import usb_line_rx_pkg::*;
#(
   parameter int LINE_LEN = 16,
   parameter int LEN_W    = $clog2(LINE_LEN + 1)
) (
   input  logic             clk_48mhz,
   input  logic             reset,
   input  logic [7:0]       uart_out_data,
   input  logic             uart_out_valid,
   output logic             uart_out_ready,
   output logic [7:0]       line_data,
   output logic             line_valid,
   input  logic             line_ready,
   output logic             line_last,
   output logic [LEN_W-1:0] line_len,
   output logic             line_overflow,
   output logic [7:0]       echo_data,
   output logic             echo_valid,
   input  logic             echo_ready
);

   localparam int IDX_W = $clog2(LINE_LEN);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       buf_mem [LINE_LEN];

   logic             echo_can_accept;
   logic             accept;
   logic             wr_en;
   logic             is_last;
   logic             draining;

`ifdef USB_LINE_RX_ECHO_EN
   logic echo_in_ready;

   usb_line_rx_echo_buf u_echo (
      .clk       (clk_48mhz),
      .rst       (reset),
      .in_data   (uart_out_data),
      .in_valid  (accept),
      .in_ready  (echo_in_ready),
      .out_data  (echo_data),
      .out_valid (echo_valid),
      .out_ready (echo_ready)
   );

   assign echo_can_accept = echo_in_ready;
`else
   logic unused_echo_ready;

   assign unused_echo_ready = echo_ready;
   assign echo_can_accept   = 1'b1;
   assign echo_valid        = 1'b0;
   assign echo_data         = 8'h00;
`endif

   assign draining       = (state_q == ST_DRAIN);
   assign uart_out_ready = !draining && echo_can_accept;
   assign accept         = uart_out_valid && uart_out_ready;
   assign is_last        = (rd_ptr_q == count_q - LEN_W'(1));

   // Line outputs read as zero outside DRAIN so idle outputs match reset values.
   assign line_valid    = draining;
   assign line_data     = draining ? buf_mem[rd_ptr_q[IDX_W-1:0]] : 8'h00;
   assign line_last     = draining && is_last;
   assign line_len      = draining ? count_q : '0;
   assign line_overflow = draining && overflow_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               if (is_term(uart_out_data)) begin
                  if (count_q != '0) begin
                     rd_ptr_d = '0;
                     state_d  = ST_DRAIN;
                  end
               end else if (is_erase(uart_out_data)) begin
                  if (count_q != '0) begin
                     count_d = count_q - LEN_W'(1);
                  end
               end else if (count_q < LEN_W'(LINE_LEN)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + LEN_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (line_ready) begin
               if (is_last) begin
                  count_d    = '0;
                  overflow_d = 1'b0;
                  rd_ptr_d   = '0;
                  state_d    = ST_COLLECT;
               end else begin
                  rd_ptr_d = rd_ptr_q + LEN_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state_q    <= ST_COLLECT;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Buffer contents need no reset: count gates every read.
   always_ff @(posedge clk_48mhz) begin
      if (wr_en) begin
         buf_mem[count_q[IDX_W-1:0]] <= uart_out_data;
      end
   end

endmodule

// File: doc/usb_line_rx.md
# usb_line_rx

Line receiver on the host-to-device side of the USB serial link. Consumes the `uart_out` byte stream from `usb_uart` and assembles characters into a line buffer, handling backspace and overflow. On CR or LF it replays the completed line as a framed byte stream with length and overflow status. It is the counterpart of the periodic text transmitter that feeds `uart_in`, and sits between `usb_uart` and the command logic in `top`.

## Interface
- `LINE_LEN`, 16: line buffer depth in bytes (≥2).
- `LEN_W`, `$clog2(LINE_LEN+1)`: width of length and count fields.

- `clk_48mhz`  in  1  system clock, 48 MHz from PLL.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_out_data`  in  8  received byte from `usb_uart`.
- `uart_out_valid`  in  1  byte present.
- `uart_out_ready`  out  1  byte accepted when `valid && ready`.
- `line_data`  out  8  current byte of completed line.
- `line_valid`  out  1  line byte available.
- `line_ready`  in  1  consumer accepts byte.
- `line_last`  out  1  final byte of line, qualified by `line_valid`.
- `line_len`  out  `LEN_W`  stored byte count, stable during drain.
- `line_overflow`  out  1  one or more bytes dropped in this line.
- `echo_data`  out  8  echoed byte toward `uart_in`.
- `echo_valid`  out  1  echo byte present.
- `echo_ready`  in  1  `uart_in_ready` from `usb_uart`.

## Operation
- Two states: COLLECT, DRAIN. Reset state: COLLECT, count=0, rd_ptr=0, overflow=0.
- COLLECT: `uart_out_ready`=1, subject to the echo rule under Configuration. `line_valid`=0.
  - Accepted byte 0x0D or 0x0A:
    - count=0: byte discarded, state unchanged. Empty lines and the LF of a CRLF pair are suppressed.
    - Otherwise: rd_ptr←0, go to DRAIN.
  - Accepted byte 0x08 or 0x7F:
    - count>0: count−1.
    - count=0: no action.
    - Overflow flag is not changed.
  - Any other byte:
    - count<LINE_LEN: buf[count]←byte, count+1.
    - count=LINE_LEN: byte dropped, overflow←1.
- DRAIN: `uart_out_ready`=0.
  - `line_valid`=1, `line_data`=buf[rd_ptr], `line_last`=(rd_ptr==count−1).
  - `line_len`=count; `line_overflow`=overflow.
  - Handshake with `line_last`=0: rd_ptr+1.
  - Handshake with `line_last`=1: count←0, overflow←0, rd_ptr←0, go to COLLECT.
  - `line_data` and `line_last` hold while `line_ready`=0.
- Reset mid-operation: all state returns to reset values immediately; any partial line is lost.
- Output reset values: `uart_out_ready`=1, `line_valid`=0, `line_last`=0, `line_data`=0, `line_len`=0, `line_overflow`=0, `echo_valid`=0, `echo_data`=0.

## Timing
- Terminator accepted at cycle N → `line_valid`=1 at N+1. First byte is visible the same cycle; reads are combinational from registered buffer.
- One byte per cycle in both COLLECT and DRAIN when the partner is ready.
- Last handshake at cycle M → `uart_out_ready`=1 at M+1.
- Counters saturate and never wrap: count stops at LINE_LEN; rd_ptr never exceeds count−1.

## Configuration
- Macro `USB_LINE_RX_ECHO_EN`.
- Defined:
  - Every byte accepted in COLLECT, including terminators and backspace, is loaded into a one-entry echo register.
  - `echo_valid` goes high the next cycle and holds with stable `echo_data` until `echo_ready`.
  - In COLLECT, `uart_out_ready` = !echo_valid || echo_ready, so accept and drain can happen in the same cycle.
  - DRAIN does not wait on echo.
- Undefined: `echo_valid`=0 and `echo_data`=0 constantly; `echo_ready` is ignored; no echo register is built.

## Structure
- Package `usb_line_rx_pkg`:
  - ASCII constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, `ASCII_BS`=8'h08, `ASCII_DEL`=8'h7F.
  - State enum for COLLECT/DRAIN.
- Sub-module `usb_line_rx_echo_buf`: single-entry valid/ready register, instantiated only under `USB_LINE_RX_ECHO_EN`.

## Test plan
- Send "AB\r", `line_ready`=1 → drains 0x41 then 0x42; `line_last` on 0x42; `line_len`=2; `line_overflow`=0.
- Send "\r\n\n" → no `line_valid`; `uart_out_ready` stays 1.
- LINE_LEN=16, send 20×'x' then "\n" → 16 bytes drained; `line_len`=16; `line_overflow`=1; overflow reads 0 on the next line.
- Send "AC", 0x08, "B\r" → line "AB", `line_len`=2.
- "HI\r" with `line_ready` low for 5 cycles → `line_data`=0x48 held; `uart_out_ready`=0 throughout DRAIN.
- With ECHO_EN, hold `echo_ready`=0 and send "Q" → `echo_valid`=1 with `echo_data`=0x51; `uart_out_ready`=0 until `echo_ready` pulses.
